// File: rtl/pwchk_pkg.sv
// Shared types and helpers for the sequential password scan checker.
// Contents:
//   state_e         scan FSM state encoding
//   DEF_*           default parameter values
//   user_slice()    extracts one user's password from the flattened table
package pwchk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_COMPARE,
    ST_RESULT,
    ST_LOCKOUT
  } state_e;

  localparam int DEF_NUM_USERS      = 10;
  localparam int DEF_NUM_DIGITS     = 4;
  localparam int DEF_DIGIT_W        = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCK_CYCLES    = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 5000;

  // Widest table/password the helper handles: 16 users x 8 digits x 8 bits.
  localparam int SLICE_MAX = 64;
  localparam int TBL_MAX   = 16 * SLICE_MAX;

  // Returns user idx's password right-aligned, bits above pw_w forced to 0
  // so callers can compare against a zero-extended entry buffer.
  function automatic logic [SLICE_MAX-1:0] user_slice(
    input logic [TBL_MAX-1:0] tbl,
    input int unsigned        idx,
    input int unsigned        pw_w
  );
    logic [SLICE_MAX-1:0] mask;
    mask = ~({SLICE_MAX{1'b1}} << pw_w);
    return SLICE_MAX'(tbl >> (idx * pw_w)) & mask;
  endfunction

endpackage

// File: rtl/pw_entry_buffer.sv
// Keypad entry buffer: shift register of NUM_DIGITS digits plus a fill count.
// Ports:
//   clk, rst   clock, async active-high reset
//   shift_i    shift digit_i in at the LSB side (ignored once full)
//   flush_i    empty the buffer and zero the count (wins over shift_i)
//   digit_i    keypad digit
//   buf_o      buffered digits, first digit entered is most significant
//   full_o     NUM_DIGITS digits held
module pw_entry_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_i,
  input  logic                          flush_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0] buf_o,
  output logic                          full_o
);

  localparam int PW_W  = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [PW_W-1:0]  buf_q, buf_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == CNT_W'(NUM_DIGITS));
  assign buf_o  = buf_q;

  generate
    if (NUM_DIGITS == 1) begin : g_one
      assign shifted = digit_i;
    end else begin : g_many
      assign shifted = {buf_q[PW_W-DIGIT_W-1:0], digit_i};
    end
  endgenerate

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (shift_i && !full_o) begin
      buf_d = shifted;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/password_scan_checker.sv
// Sequential password checker: serial digit entry, one-user-per-cycle scan of
// the password table, pulsed result, consecutive-failure count and lockout.
// Optional macro PWCHK_TIMEOUT_EN adds an entry inactivity timeout and the
// timeout_pulse output.
// Ports:
//   clk, rst                       clock, async active-high reset
//   digit_valid, digit_in          keypad digit strobe and value
//   enter, clear                   submit / discard strobes
//   pw_table, user_en              live password table and per-user enables
//   busy                           scanning or locked out
//   done                           one-cycle result strobe
//   success, user_onehot, user_idx result, held until the next entry starts
//   locked, fail_cnt               lockout flag and consecutive failures
//   timeout_pulse                  (PWCHK_TIMEOUT_EN only) entry timed out
module password_scan_checker
  import pwchk_pkg::*;
#(
  parameter int NUM_USERS      = DEF_NUM_USERS,
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDX_W  = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
  localparam int FAIL_W = $clog2(MAX_FAILS + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    digit_valid,
  input  logic [DIGIT_W-1:0]                      digit_in,
  input  logic                                    enter,
  input  logic                                    clear,
  input  logic [NUM_USERS*NUM_DIGITS*DIGIT_W-1:0] pw_table,
  input  logic [NUM_USERS-1:0]                    user_en,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    success,
  output logic [NUM_USERS-1:0]                    user_onehot,
  output logic [IDX_W-1:0]                        user_idx,
  output logic                                    locked,
`ifdef PWCHK_TIMEOUT_EN
  output logic                                    timeout_pulse,
`endif
  output logic [FAIL_W-1:0]                       fail_cnt
);

  localparam int PW_W   = NUM_DIGITS * DIGIT_W;
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       scan_q, scan_d, idx_q, idx_d;
  logic [LOCK_W-1:0]      lock_q, lock_d;
  logic [FAIL_W-1:0]      fail_q, fail_d, fail_inc;
  logic                   success_q, success_d;
  logic [NUM_USERS-1:0]   onehot_q, onehot_d;

  logic                   buf_shift, buf_flush, buf_full, match;
  logic [PW_W-1:0]        buf_val;
  logic [SLICE_MAX-1:0]   cur_slice;

  pw_entry_buffer #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .shift_i (buf_shift),
    .flush_i (buf_flush),
    .digit_i (digit_in),
    .buf_o   (buf_val),
    .full_o  (buf_full)
  );

  // Table is read live: the user under test is whatever pw_table holds now.
  assign cur_slice = user_slice(TBL_MAX'(pw_table), 32'(scan_q), PW_W);
  assign match     = user_en[scan_q] && (SLICE_MAX'(buf_val) == cur_slice);

`ifdef PWCHK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_q, idle_d;
  logic            timeout_hit;

  // Counts idle ENTRY cycles; any digit strobe seen in ENTRY restarts it.
  assign idle_d      = (state_q == ST_ENTRY && !digit_valid) ? idle_q + TO_W'(1) : '0;
  assign timeout_hit = (state_q == ST_ENTRY) && !clear && !enter && !digit_valid &&
                       (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      scan_q    <= '0;
      lock_q    <= '0;
      fail_q    <= '0;
      success_q <= 1'b0;
      onehot_q  <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      lock_q    <= lock_d;
      fail_q    <= fail_d;
      success_q <= success_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
    end
  end

  // Next state. Result fields start cleared at the first digit of an entry,
  // so every failure path leaves them at zero without touching them again.
  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    lock_d    = lock_q;
    fail_d    = fail_q;
    success_d = success_q;
    onehot_d  = onehot_q;
    idx_d     = idx_q;
    fail_inc  = fail_q + FAIL_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (digit_valid && !clear && !enter) begin
          state_d   = ST_ENTRY;
          success_d = 1'b0;
          onehot_d  = '0;
          idx_d     = '0;
        end
      end
      ST_ENTRY: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (enter) begin
          if (buf_full) begin
            state_d = ST_COMPARE;
            scan_d  = '0;
          end else begin
            state_d = ST_RESULT;
          end
        end
`ifdef PWCHK_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_COMPARE: begin
        if (match) begin
          state_d   = ST_RESULT;
          success_d = 1'b1;
          onehot_d  = NUM_USERS'(1) << scan_q;
          idx_d     = scan_q;
        end else if (scan_q == IDX_W'(NUM_USERS - 1)) begin
          state_d = ST_RESULT;
        end else begin
          scan_d = scan_q + IDX_W'(1);
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
        if (success_q) begin
          fail_d = '0;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FAIL_W'(MAX_FAILS)) begin
            state_d = ST_LOCKOUT;
            lock_d  = LOCK_W'(LOCK_CYCLES);
          end
        end
      end
      ST_LOCKOUT: begin
        // Loaded with LOCK_CYCLES, leaves on the cycle it reads 1: exactly
        // LOCK_CYCLES cycles spent here.
        lock_d = lock_q - LOCK_W'(1);
        if (lock_q == LOCK_W'(1)) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and entry-buffer control.
  always_comb begin
    busy      = (state_q == ST_COMPARE) || (state_q == ST_LOCKOUT);
    done      = (state_q == ST_RESULT);
    locked    = (state_q == ST_LOCKOUT);
    buf_shift = ((state_q == ST_IDLE) || (state_q == ST_ENTRY)) &&
                digit_valid && !clear && !enter;
    buf_flush = ((state_q == ST_ENTRY) && clear) || (state_q == ST_RESULT);
`ifdef PWCHK_TIMEOUT_EN
    timeout_pulse = timeout_hit;
    if (timeout_hit) buf_flush = 1'b1;
`endif
  end

  assign success     = success_q;
  assign user_onehot = onehot_q;
  assign user_idx    = idx_q;
  assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_password_scan_checker.sv
// Directed bench for password_scan_checker at default sizes.
module tb_password_scan_checker;
  localparam int NU = 10;
  localparam int ND = 4;
  localparam int DW = 4;
`ifdef PWCHK_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 5000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic digit_valid = 1'b0, enter = 1'b0, clear = 1'b0;
  logic [DW-1:0] digit_in = '0;
  logic [NU*ND*DW-1:0] pw_table;
  logic [NU-1:0] user_en;
  logic busy, done, success, locked;
  logic [NU-1:0] user_onehot;
  logic [3:0] user_idx;
  logic [1:0] fail_cnt;
`ifdef PWCHK_TIMEOUT_EN
  logic timeout_pulse;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  password_scan_checker #(
    .NUM_USERS(NU), .NUM_DIGITS(ND), .DIGIT_W(DW),
    .MAX_FAILS(3), .LOCK_CYCLES(1000), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit_in(digit_in),
    .enter(enter), .clear(clear), .pw_table(pw_table), .user_en(user_en),
    .busy(busy), .done(done), .success(success), .user_onehot(user_onehot),
    .user_idx(user_idx), .locked(locked),
`ifdef PWCHK_TIMEOUT_EN
    .timeout_pulse(timeout_pulse),
`endif
    .fail_cnt(fail_cnt)
  );

  // ---- stimulus helpers (called at a negedge, return at a negedge) ----
  task automatic set_default_table();
    for (int u = 0; u < NU; u++) pw_table[u*16 +: 16] = 16'h9000 + 16'(u);
    pw_table[2*16 +: 16] = 16'h1234;
    user_en = '1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic key4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) key(v[i*4 +: 4]);
  endtask

  // Pulses enter, returns cycles until done (64 on expiry) and whether busy rose.
  task automatic submit(output int cyc, output bit bsy);
    enter = 1'b1; cyc = 0; bsy = 1'b0;
    do begin
      @(negedge clk);
      enter = 1'b0;
      cyc++;
      if (busy) bsy = 1'b1;
    end while (!done && cyc < 64);
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, success, locked, user_onehot, user_idx, fail_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {busy, done, success, locked, user_onehot, user_idx, fail_cnt});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_short_entry();
    int cyc; bit bsy;
    key(4'd9); key(4'd8);
    submit(cyc, bsy);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL short_latency: got %0d required 1", cyc); end
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b required 0", bsy); end
    checks++; if (success !== 1'b0 || user_idx !== 4'd0) begin
      errors++; $display("FAIL short_result: got success=%b idx=%0d required 0/0", success, user_idx); end
    @(negedge clk);
    checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL short_failcnt: got %0d required 1", fail_cnt); end
  endtask

  task automatic test_match();
    int cyc; bit bsy;
    key4(16'h1234);
    submit(cyc, bsy);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL match_latency: got %0d required 4", cyc); end
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL match_busy: got %b required 1", bsy); end
    checks++; if (success !== 1'b1 || user_onehot !== 10'b0000000100 || user_idx !== 4'd2) begin
      errors++; $display("FAIL match_result: got s=%b oh=%b idx=%0d required 1/0000000100/2",
                         success, user_onehot, user_idx); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || success !== 1'b1 || fail_cnt !== 2'd0) begin
      errors++; $display("FAIL match_hold: got done=%b s=%b fail=%0d required 0/1/0", done, success, fail_cnt); end
  endtask

  task automatic test_priority();
    int cyc; bit bsy;
    pw_table[1*16 +: 16] = 16'h5555;
    pw_table[6*16 +: 16] = 16'h5555;
    key4(16'h5555);
    submit(cyc, bsy);
    checks++; if (cyc !== 3 || user_idx !== 4'd1 || user_onehot !== 10'b0000000010) begin
      errors++; $display("FAIL prio_lowest: got cyc=%0d idx=%0d oh=%b required 3/1/0000000010",
                         cyc, user_idx, user_onehot); end
    @(negedge clk);
    user_en[1] = 1'b0;
    key4(16'h5555);
    submit(cyc, bsy);
    checks++; if (cyc !== 8 || user_idx !== 4'd6 || user_onehot !== 10'b0001000000 || success !== 1'b1) begin
      errors++; $display("FAIL prio_disabled: got cyc=%0d idx=%0d oh=%b s=%b required 8/6/0001000000/1",
                         cyc, user_idx, user_onehot, success); end
    @(negedge clk);
    set_default_table();
  endtask

  task automatic test_clear();
    int cyc; bit bsy; bit seen;
    key(4'd1); key(4'd2); key(4'd3);
    clear = 1'b1; enter = 1'b1;
    @(negedge clk);
    clear = 1'b0; enter = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clear_no_done: got %b required 0", seen); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL clear_failcnt: got %0d required 0", fail_cnt); end
    // Count must have been emptied: four fresh digits form a full entry.
    key4(16'h1234);
    submit(cyc, bsy);
    checks++; if (cyc !== 4 || success !== 1'b1) begin
      errors++; $display("FAIL clear_reentry: got cyc=%0d s=%b required 4/1", cyc, success); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int cyc; bit bsy;
    key4(16'h1234); key(4'd5); key(4'd6);
    submit(cyc, bsy);
    checks++; if (success !== 1'b1 || user_idx !== 4'd2) begin
      errors++; $display("FAIL overflow_first4: got s=%b idx=%0d required 1/2", success, user_idx); end
    @(negedge clk);
  endtask

  task automatic test_lockout();
    int cyc; bit bsy; int n;
    for (int k = 1; k <= 3; k++) begin
      key4(16'h0000);
      submit(cyc, bsy);
      checks++; if (success !== 1'b0) begin errors++; $display("FAIL lock_fail%0d: got s=%b required 0", k, success); end
      @(negedge clk);
      checks++; if (fail_cnt !== 2'(k)) begin errors++; $display("FAIL lock_failcnt%0d: got %0d required %0d", k, fail_cnt, k); end
    end
    n = 0;
    while (locked && n < 2000) begin
      n++;
      digit_in = 4'd1;
      digit_valid = (n % 50 == 0);
      enter = (n == 300);
      @(negedge clk);
    end
    digit_valid = 1'b0; enter = 1'b0;
    checks++; if (n !== 1000) begin errors++; $display("FAIL lock_duration: got %0d required 1000", n); end
    checks++; if (fail_cnt !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL lock_exit: got fail=%0d busy=%b required 0/0", fail_cnt, busy); end
    key4(16'h1234);
    submit(cyc, bsy);
    checks++; if (cyc !== 4 || success !== 1'b1) begin
      errors++; $display("FAIL lock_after: got cyc=%0d s=%b required 4/1", cyc, success); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; bit bsy;
    key4(16'h0000); submit(cyc, bsy); @(negedge clk);   // fail_cnt = 1
    key4(16'h1234);
    enter = 1'b1; @(negedge clk); enter = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midcmp_busy: got %b required 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, success, locked, user_onehot, user_idx, fail_cnt} !== '0) begin
      errors++; $display("FAIL midcmp_reset: got %b required all zero",
                         {busy, done, success, locked, user_onehot, user_idx, fail_cnt}); end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    for (int k = 0; k < 3; k++) begin key4(16'h0000); submit(cyc, bsy); @(negedge clk); end
    repeat (5) @(negedge clk);
    checks++; if (locked !== 1'b1 || fail_cnt !== 2'd3) begin
      errors++; $display("FAIL midlock_pre: got locked=%b fail=%0d required 1/3", locked, fail_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, success, locked, user_onehot, user_idx, fail_cnt} !== '0) begin
      errors++; $display("FAIL midlock_reset: got %b required all zero",
                         {busy, done, success, locked, user_onehot, user_idx, fail_cnt}); end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    key4(16'h1234);
    submit(cyc, bsy);
    checks++; if (cyc !== 4 || success !== 1'b1) begin
      errors++; $display("FAIL midlock_after: got cyc=%0d s=%b required 4/1", cyc, success); end
    @(negedge clk);
  endtask

`ifdef PWCHK_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; bit bsy;
    key(4'd1);
    cyc = 1;
    while (!timeout_pulse && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 20) begin errors++; $display("FAIL timeout_cycles: got %0d required 20", cyc); end
    @(negedge clk);
    checks++; if (timeout_pulse !== 1'b0 || fail_cnt !== 2'd0 || done !== 1'b0) begin
      errors++; $display("FAIL timeout_after: got tp=%b fail=%0d done=%b required 0/0/0",
                         timeout_pulse, fail_cnt, done); end
    key4(16'h1234);
    submit(cyc, bsy);
    checks++; if (cyc !== 4 || success !== 1'b1) begin
      errors++; $display("FAIL timeout_reentry: got cyc=%0d s=%b required 4/1", cyc, success); end
    @(negedge clk);
  endtask
`endif

  initial begin
    set_default_table();
    test_reset();
    test_short_entry();
    test_match();
    test_priority();
    test_clear();
    test_overflow();
    test_lockout();
    test_reset_mid();
`ifdef PWCHK_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/password_scan_checker.md
Name: password_scan_checker

Overview:
- Sequential, parametrised successor to the door system's combinational password comparator.
- Digits arrive serially from the keypad decoder into an entry buffer; on enter, the stored user passwords are scanned one per cycle.
- Reports a pulsed result with a one-hot and binary user ID.
- Adds a failed-attempt counter and a timed lockout for the door controller.

Parameters:
- NUM_USERS, 10, number of stored user passwords (1..16).
- NUM_DIGITS, 4, digits per password (1..8).
- DIGIT_W, 4, bits per digit (BCD keypad code).
- MAX_FAILS, 3, consecutive failures that trigger lockout (>=1).
- LOCK_CYCLES, 1000, lockout duration in clk cycles (>=1).
- TIMEOUT_CYCLES, 5000, entry inactivity limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- digit_valid  in  1  single-cycle strobe: digit_in is a new keypress.
- digit_in  in  DIGIT_W  keypad digit.
- enter  in  1  single-cycle strobe: submit the entry.
- clear  in  1  single-cycle strobe: discard the entry.
- pw_table  in  NUM_USERS*NUM_DIGITS*DIGIT_W  flattened passwords.
  - User u occupies slice [u*NUM_DIGITS*DIGIT_W +: NUM_DIGITS*DIGIT_W].
  - Most significant digit is the first digit entered.
- user_en  in  NUM_USERS  per-user enable; a disabled user never matches.
- busy  out  1  high in COMPARE and LOCKOUT.
- done  out  1  one-cycle pulse when a result is valid.
- success  out  1  result; held until the next entry starts.
- user_onehot  out  NUM_USERS  matched user, bit0 = user 1; held with success.
- user_idx  out  $clog2(NUM_USERS)  binary form of the match; 0 on failure.
- locked  out  1  high during lockout.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count.

Behaviour:
- Reset values (asynchronous rst): all outputs 0, entry buffer 0, digit count 0, state IDLE.
- States: IDLE, ENTRY, COMPARE, RESULT, LOCKOUT.
- IDLE:
  - digit_valid: shift the digit into the buffer LSB side, count = 1, go to ENTRY.
  - On that same edge, clear success, user_onehot and user_idx.
- ENTRY:
  - digit_valid while count < NUM_DIGITS: shift the digit in, count++.
  - digit_valid while count == NUM_DIGITS: digit ignored, buffer unchanged.
  - enter with count == NUM_DIGITS: go to COMPARE, scan index 0.
  - enter with count < NUM_DIGITS: go to RESULT as a failure, no scan.
  - clear: empty the buffer, count = 0, go to IDLE; fail_cnt unchanged.
- Simultaneous strobes:
  - clear beats enter, which beats digit_valid.
  - When enter wins, the same-cycle digit is dropped.
- COMPARE:
  - One user per cycle, index 0 upward. Match requires user_en[i] and buffer == slice i.
  - First match: record index, go to RESULT. This gives lowest-index priority, as in the existing comparator.
  - Index NUM_USERS-1 checked with no match: go to RESULT as a failure.
  - Worst-case latency from enter to done: NUM_USERS+1 cycles.
  - All keypad strobes are ignored.
- RESULT (one cycle):
  - Pulse done and drive success, user_onehot, user_idx.
  - On success: fail_cnt = 0.
  - On failure: fail_cnt++. If the new value equals MAX_FAILS, go to LOCKOUT and load the lock counter with LOCK_CYCLES.
  - Otherwise return to IDLE and clear the buffer.
- LOCKOUT:
  - locked = 1; keypad strobes ignored; counter decrements every cycle.
  - At 0: go to IDLE, fail_cnt = 0, locked = 0.
- pw_table and user_en are sampled live during COMPARE. Changing them mid-scan is permitted; the result reflects the values seen at each index's cycle.
- rst mid-operation, including during lockout, returns everything to reset values. Lockout does not persist across reset.

Optional Feature:
- Macro: PWCHK_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ENTRY and reloads on every accepted digit_valid.
  - After TIMEOUT_CYCLES cycles with no keypress, the entry is discarded as if clear were pressed.
  - A timeout is not counted as a failure.
  - Extra output port timeout_pulse (1 bit) pulses for one cycle on each timeout.
- Undefined: no counter and no timeout_pulse port; ENTRY waits indefinitely.

Decomposition:
- Package pwchk_pkg:
  - State enum type.
  - Default parameter constants.
  - Function extracting user slice i from pw_table.
- Sub-module pw_entry_buffer:
  - Shift register plus digit counter.
  - Inputs: shift, flush.
  - Outputs: buffer, full.
- Scan FSM, fail counter and lock counter stay in the top module.

Test Plan:
- Defaults; user 3 = 1,2,3,4, others distinct; enter 1,2,3,4 then enter -> done 4 cycles after enter, success=1, user_onehot=0000000100, user_idx=2, fail_cnt=0.
- Users 2 and 7 both = 5,5,5,5; key 5,5,5,5 -> user_idx=1 (lowest wins). Repeat with user_en[1]=0 -> user_idx=6.
- Three wrong 4-digit entries -> fail_cnt 1, 2, then locked=1 for exactly 1000 cycles. Keypresses during lockout have no effect. Afterwards fail_cnt=0.
- Key 9,8 then enter -> done the cycle after RESULT entry, success=0, fail_cnt=1, no scan (busy stays 0).
- Key 1,2,3 then clear + enter in the same cycle -> IDLE, no done, fail_cnt unchanged. Key 6 digits -> only the first 4 kept.
- rst asserted mid-COMPARE and mid-LOCKOUT -> all outputs 0 immediately. With PWCHK_TIMEOUT_EN and TIMEOUT_CYCLES=20: key 1 then wait 20 cycles -> timeout_pulse=1, state IDLE, fail_cnt unchanged.
